// File: rtl/addsub_stream_checker.sv
// addsub_stream_checker
// Self-test initiator for a pipelined adder/subtractor. It issues operand
// beats (LFSR-generated or fixed), keeps the expected {carry_borrow, result}
// of every beat in an in-order FIFO and compares each returned beat against
// the FIFO head. It reports pass/fail, an error count, a drain timeout and
// the data of the first mismatch.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      one-cycle run request (honoured in IDLE/DONE)
//   num_ops                    number of beats to issue in the run
//   mode                       0 = LFSR operands, 1 = cfg_a/cfg_b/cfg_op
//   seed                       LFSR seed (0 is replaced by 1)
//   cfg_a, cfg_b, cfg_op       fixed operands for mode 1
//   dut_a, dut_b, dut_op       operand beat towards the datapath
//   dut_valid                  beat valid towards the datapath
//   dut_result, dut_carry      returned result and carry/borrow
//   dut_valid_out              returned beat valid
//   busy, done, pass, timeout  run status
//   err_count                  saturating mismatch/spurious/leftover count
//   first_err_idx/exp/got      return index and data of the first error
module addsub_stream_checker #(
    parameter int DATAWIDTH           = 8,
    parameter int NUM_PIPELINE_STAGES = 4,
    parameter int FIFO_DEPTH          = 8,
    parameter int TIMEOUT             = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          num_ops,
    input  logic                 mode,
    input  logic [31:0]          seed,
    input  logic [DATAWIDTH-1:0] cfg_a,
    input  logic [DATAWIDTH-1:0] cfg_b,
    input  logic                 cfg_op,
    output logic [DATAWIDTH-1:0] dut_a,
    output logic [DATAWIDTH-1:0] dut_b,
    output logic                 dut_op,
    output logic                 dut_valid,
    input  logic [DATAWIDTH-1:0] dut_result,
    input  logic                 dut_carry,
    input  logic                 dut_valid_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [15:0]          err_count,
    output logic [15:0]          first_err_idx,
    output logic [DATAWIDTH:0]   first_err_exp,
    output logic [DATAWIDTH:0]   first_err_got
);

    localparam int RW = DATAWIDTH + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // The drain window can never be shorter than the datapath latency.
    localparam int DRAIN_LIMIT = (TIMEOUT > NUM_PIPELINE_STAGES) ? TIMEOUT : NUM_PIPELINE_STAGES + 1;
    localparam int IW = $clog2(DRAIN_LIMIT + 1);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [31:0]     lfsr, lfsr_next;
    logic [15:0]     num_ops_r, num_ops_next;
    logic            mode_r, mode_next;
    logic [15:0]     issued, issued_next;
    logic [15:0]     ret_idx, ret_idx_next;
    logic [IW-1:0]   idle_cnt, idle_next;
    logic [AW-1:0]   wr_ptr, wr_next, wr_base;
    logic [AW-1:0]   rd_ptr, rd_next;
    logic [CW-1:0]   count, count_next;
    logic [RW-1:0]   fifo_mem [FIFO_DEPTH];

    logic            start_accept, issue, check, pop, ret_err, full, cur_mode;
    logic [31:0]     cur_lfsr;
    logic [DATAWIDTH-1:0] beat_a, beat_b;
    logic            beat_op;
    logic [RW-1:0]   beat_exp, head, got, ret_exp;
    logic [16:0]     sat_sum;
    logic [15:0]     err_next, fidx_next;
    logic [RW-1:0]   fexp_next, fgot_next;
    logic            timeout_next, pass_next;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // Next-state, issue and compare logic. The start cycle already issues
    // the first beat, using the freshly loaded seed and a cleared FIFO.
    always_comb begin
        start_accept = start && ((state == IDLE) || (state == DONE));
        cur_lfsr     = start_accept ? ((seed == 32'd0) ? 32'd1 : seed) : lfsr;
        cur_mode     = start_accept ? mode : mode_r;
        beat_a       = cur_mode ? cfg_a  : cur_lfsr[DATAWIDTH-1:0];
        beat_b       = cur_mode ? cfg_b  : cur_lfsr[2*DATAWIDTH-1:DATAWIDTH];
        beat_op      = cur_mode ? cfg_op : cur_lfsr[31];
        beat_exp     = beat_op ? ({1'b0, beat_a} + {1'b0, ~beat_b} + RW'(1))
                               : ({1'b0, beat_a} + {1'b0, beat_b});
        full         = (count == CW'(FIFO_DEPTH));
        issue        = start_accept ? (num_ops != 16'd0)
                                    : ((state == RUN) && (issued < num_ops_r) && !full);
        wr_base      = start_accept ? '0 : wr_ptr;

        got          = {dut_carry, dut_result};
        head         = fifo_mem[rd_ptr];
        check        = dut_valid_out && (state != IDLE) && !start_accept;
        pop          = check && (count != '0);
        ret_exp      = (count != '0) ? head : '0;
        ret_err      = check && ((count == '0) || (head != got));
        sat_sum      = {1'b0, err_count} + 17'(count);

        state_next   = state;
        lfsr_next    = lfsr;
        num_ops_next = num_ops_r;
        mode_next    = mode_r;
        issued_next  = issued;
        ret_idx_next = ret_idx;
        idle_next    = idle_cnt;
        wr_next      = wr_ptr;
        rd_next      = rd_ptr;
        count_next   = count;
        err_next     = err_count;
        fidx_next    = first_err_idx;
        fexp_next    = first_err_exp;
        fgot_next    = first_err_got;
        timeout_next = timeout;
        pass_next    = pass;

        if (start_accept) begin
            lfsr_next    = cur_lfsr;
            num_ops_next = num_ops;
            mode_next    = mode;
            issued_next  = '0;
            ret_idx_next = '0;
            idle_next    = '0;
            wr_next      = '0;
            rd_next      = '0;
            count_next   = '0;
            err_next     = '0;
            fidx_next    = '0;
            fexp_next    = '0;
            fgot_next    = '0;
            timeout_next = 1'b0;
            pass_next    = (num_ops == 16'd0);
            state_next   = (num_ops == 16'd0) ? DONE : RUN;
        end

        if (check) begin
            ret_idx_next = ret_idx + 16'd1;
            if (pop) begin
                rd_next = rd_ptr + AW'(1);
            end
            if (ret_err) begin
                if (err_count == 16'd0) begin
                    fidx_next = ret_idx;
                    fexp_next = ret_exp;
                    fgot_next = got;
                end
                if (err_count != 16'hFFFF) begin
                    err_next = err_count + 16'd1;
                end
            end
        end

        if (issue) begin
            lfsr_next   = lfsr_step(cur_lfsr);
            issued_next = issued_next + 16'd1;
            wr_next     = wr_base + AW'(1);
        end
        count_next = count_next + CW'(issue) - CW'(pop);

        case (state)
            RUN: begin
                if (issued == num_ops_r) begin
                    state_next = DRAIN;
                    idle_next  = '0;
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    state_next = DONE;
                    pass_next  = (err_next == 16'd0);
                end else if (dut_valid_out) begin
                    idle_next = '0;
                end else if (idle_cnt == IW'(DRAIN_LIMIT - 1)) begin
                    // Leftover beats are lost returns; flush them so a late
                    // pulse in DONE is judged as spurious.
                    timeout_next = 1'b1;
                    err_next     = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
                    if (err_count == 16'd0) begin
                        fidx_next = ret_idx;
                        fexp_next = head;
                        fgot_next = '0;
                    end
                    rd_next    = wr_ptr;
                    count_next = '0;
                    pass_next  = 1'b0;
                    state_next = DONE;
                end else begin
                    idle_next = idle_cnt + IW'(1);
                end
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= 32'd1;
            num_ops_r     <= '0;
            mode_r        <= 1'b0;
            issued        <= '0;
            ret_idx       <= '0;
            idle_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            dut_a         <= '0;
            dut_b         <= '0;
            dut_op        <= 1'b0;
            dut_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            state         <= state_next;
            lfsr          <= lfsr_next;
            num_ops_r     <= num_ops_next;
            mode_r        <= mode_next;
            issued        <= issued_next;
            ret_idx       <= ret_idx_next;
            idle_cnt      <= idle_next;
            wr_ptr        <= wr_next;
            rd_ptr        <= rd_next;
            count         <= count_next;
            dut_valid     <= issue;
            if (issue) begin
                dut_a  <= beat_a;
                dut_b  <= beat_b;
                dut_op <= beat_op;
            end
            busy          <= (state_next == RUN) || (state_next == DRAIN);
            done          <= (state_next == DONE);
            pass          <= pass_next;
            timeout       <= timeout_next;
            err_count     <= err_next;
            first_err_idx <= fidx_next;
            first_err_exp <= fexp_next;
            first_err_got <= fgot_next;
        end
    end

    // Expected-value storage; emptiness is tracked by count, so no reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_mem[wr_base] <= beat_exp;
        end
    end

endmodule

// File: tb/tb_addsub_stream_checker.sv
// tb_addsub_stream_checker
// Drives addsub_stream_checker against an ideal 4-stage adder/subtractor
// model with optional return corruption, dropped returns and spurious pulses.
module tb_addsub_stream_checker;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   num_ops = '0;
    logic          mode = 1'b0;
    logic [31:0]   seed = '0;
    logic [DW-1:0] cfg_a = '0, cfg_b = '0;
    logic          cfg_op = 1'b0;
    logic [DW-1:0] dut_a, dut_b, dut_result;
    logic          dut_op, dut_valid, dut_carry, dut_valid_out;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count, first_err_idx;
    logic [DW:0]   first_err_exp, first_err_got;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addsub_stream_checker #(
        .DATAWIDTH(DW), .NUM_PIPELINE_STAGES(4), .FIFO_DEPTH(8), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .mode(mode),
        .seed(seed), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_op(cfg_op),
        .dut_a(dut_a), .dut_b(dut_b), .dut_op(dut_op), .dut_valid(dut_valid),
        .dut_result(dut_result), .dut_carry(dut_carry), .dut_valid_out(dut_valid_out),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    // Ideal datapath model: four register stages, carry = no-borrow on subtract.
    logic [3:0]  pv = '0;
    logic [DW:0] pcr [4];
    int          mdl_ret = 0;
    logic        mdl_clr = 1'b0;
    int          flip_idx = -1;
    int          drop_idx = -1;
    logic        spur = 1'b0;

    function automatic logic [DW:0] ideal(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
        logic [DW:0] r;
        if (op) begin
            r[DW-1:0] = a - b;
            r[DW]     = (a >= b);
        end else begin
            r = a + b;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        pv     <= {pv[2:0], dut_valid};
        pcr[0] <= ideal(dut_a, dut_b, dut_op);
        for (int i = 1; i < 4; i++) pcr[i] <= pcr[i-1];
        if (mdl_clr) mdl_ret <= 0;
        else if (pv[3]) mdl_ret <= mdl_ret + 1;
    end

    assign dut_valid_out = (pv[3] && !(drop_idx >= 0 && mdl_ret == drop_idx)) || spur;
    assign {dut_carry, dut_result} = pcr[3] ^ ((flip_idx >= 0 && mdl_ret == flip_idx) ? 9'h001 : 9'h000);

    function automatic logic [31:0] lfsr_model(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    typedef struct {
        logic        mode;
        logic [31:0] seed;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        op;
        logic [15:0] n;
        int          flip;
        int          drop;
        logic [8:0]  exp_cr;
        logic        exp_pass;
        logic [15:0] exp_err;
        logic        exp_to;
        logic        chk_first;
        logic [15:0] exp_fidx;
        logic [8:0]  exp_fexp;
        logic [8:0]  exp_fgot;
    } vec_t;

    function automatic vec_t mk(input logic md, input logic [31:0] sd, input logic [7:0] a,
                                input logic [7:0] b, input logic op, input logic [15:0] n,
                                input int fl, input int dr, input logic [8:0] cr, input logic ps,
                                input logic [15:0] er, input logic to, input logic cf,
                                input logic [15:0] fi, input logic [8:0] fe, input logic [8:0] fg);
        vec_t v;
        v.mode = md; v.seed = sd; v.a = a; v.b = b; v.op = op; v.n = n;
        v.flip = fl; v.drop = dr; v.exp_cr = cr; v.exp_pass = ps; v.exp_err = er;
        v.exp_to = to; v.chk_first = cf; v.exp_fidx = fi; v.exp_fexp = fe; v.exp_fgot = fg;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Runs one complete checker pass and verifies the issue stream and results.
    task automatic applyStimulus(input vec_t v, input int row);
        int          cyc, issued, rets, last_v, beat_bad, ret_bad, max_fl;
        logic [31:0] m;
        logic [16:0] exp_beat;
        bit          got_done;
        @(negedge clk);
        mode = v.mode; seed = v.seed; cfg_a = v.a; cfg_b = v.b; cfg_op = v.op; num_ops = v.n;
        flip_idx = v.flip; drop_idx = v.drop;
        mdl_clr = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdl_clr = 1'b0;
        checkOutput($sformatf("row%0d first_valid", row), 96'(dut_valid), 96'(v.n != 16'd0));
        m = (v.seed == 32'd0) ? 32'd1 : v.seed;
        cyc = 0; issued = 0; rets = 0; last_v = -1; beat_bad = 0; ret_bad = 0; max_fl = 0;
        got_done = 1'b0;
        while (cyc < int'(v.n) + 300) begin
            if (dut_valid) begin
                issued++;
                last_v = cyc;
                exp_beat = v.mode ? {v.op, v.b, v.a} : {m[31], m[15:8], m[7:0]};
                if ({dut_op, dut_b, dut_a} !== exp_beat) beat_bad++;
                m = lfsr_model(m);
            end
            if (dut_valid_out) begin
                rets++;
                if (v.mode && v.flip < 0 && {dut_carry, dut_result} !== v.exp_cr) ret_bad++;
            end
            if (issued - rets > max_fl) max_fl = issued - rets;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput($sformatf("row%0d done_reached", row), 96'(got_done), 96'(1));
        checkOutput($sformatf("row%0d pass", row), 96'(pass), 96'(v.exp_pass));
        checkOutput($sformatf("row%0d err_count", row), 96'(err_count), 96'(v.exp_err));
        checkOutput($sformatf("row%0d timeout", row), 96'(timeout), 96'(v.exp_to));
        checkOutput($sformatf("row%0d busy_low", row), 96'(busy), 96'(0));
        checkOutput($sformatf("row%0d issued", row), 96'(issued), 96'(v.n));
        checkOutput($sformatf("row%0d beat_content_bad", row), 96'(beat_bad), 96'(0));
        if (v.n != 16'd0)
            checkOutput($sformatf("row%0d back_to_back_last", row), 96'(last_v), 96'(int'(v.n) - 1));
        checkOutput($sformatf("row%0d returns", row), 96'(rets), 96'(int'(v.n) - ((v.drop >= 0) ? 1 : 0)));
        checkOutput($sformatf("row%0d return_value_bad", row), 96'(ret_bad), 96'(0));
        checkOutput($sformatf("row%0d max_in_flight_le5", row), 96'(max_fl <= 5), 96'(1));
        if (v.chk_first)
            checkOutput($sformatf("row%0d first_err", row),
                        96'({first_err_idx, first_err_exp, first_err_got}),
                        96'({v.exp_fidx, v.exp_fexp, v.exp_fgot}));
        flip_idx = -1;
        drop_idx = -1;
    endtask

    function automatic logic [95:0] all_outputs();
        return 96'({dut_a, dut_b, dut_op, dut_valid, busy, done, pass, timeout,
                    err_count, first_err_idx, first_err_exp, first_err_got});
    endfunction

    vec_t vecs [9];
    vec_t drop_vec;
    int   seen_valid;

    initial begin
        vecs[0] = mk(1, 32'h0,    8'h05, 8'h03, 1, 16'd4,    -1, -1, 9'h102, 1, 16'd0, 0, 1, 16'd0, 9'h000, 9'h000);
        vecs[1] = mk(1, 32'h0,    8'hFF, 8'h01, 0, 16'd1,    -1, -1, 9'h100, 1, 16'd0, 0, 1, 16'd0, 9'h000, 9'h000);
        vecs[2] = mk(1, 32'h0,    8'h00, 8'h01, 1, 16'd1,    -1, -1, 9'h0FF, 1, 16'd0, 0, 1, 16'd0, 9'h000, 9'h000);
        vecs[3] = mk(1, 32'h0,    8'h7F, 8'h7F, 0, 16'd6,    -1, -1, 9'h0FE, 1, 16'd0, 0, 1, 16'd0, 9'h000, 9'h000);
        vecs[4] = mk(1, 32'h0,    8'h80, 8'h80, 1, 16'd3,    -1, -1, 9'h100, 1, 16'd0, 0, 1, 16'd0, 9'h000, 9'h000);
        vecs[5] = mk(0, 32'hACE1, 8'h00, 8'h00, 0, 16'd1000, -1, -1, 9'h000, 1, 16'd0, 0, 1, 16'd0, 9'h000, 9'h000);
        vecs[6] = mk(0, 32'h0,    8'h00, 8'h00, 0, 16'd25,   -1, -1, 9'h000, 1, 16'd0, 0, 1, 16'd0, 9'h000, 9'h000);
        vecs[7] = mk(1, 32'h0,    8'h12, 8'h34, 0, 16'd0,    -1, -1, 9'h000, 1, 16'd0, 0, 1, 16'd0, 9'h000, 9'h000);
        vecs[8] = mk(1, 32'h0,    8'h05, 8'h03, 0, 16'd5,     2, -1, 9'h008, 0, 16'd1, 0, 1, 16'd2, 9'h008, 9'h009);
        drop_vec = mk(1, 32'h0,   8'h05, 8'h03, 0, 16'd3,    -1,  2, 9'h008, 0, 16'd1, 1, 0, 16'd0, 9'h000, 9'h000);

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", all_outputs(), 96'(0));
        rst = 1'b0;

        for (int r = 0; r < 9; r++) applyStimulus(vecs[r], r);

        // Lost last return: drain timeout, then a spurious pulse while DONE.
        applyStimulus(drop_vec, 9);
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        checkOutput("spurious_err_count", 96'(err_count), 96'(2));
        checkOutput("spurious_done_held", 96'({done, pass, timeout}), 96'(3'b101));

        // Reset in the middle of a long run; start during RUN must be ignored.
        @(negedge clk);
        mode = 1'b0; seed = 32'h1234; num_ops = 16'd1000; mdl_clr = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdl_clr = 1'b0;
        repeat (5) @(negedge clk);
        num_ops = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_ignored_in_run", 96'({busy, done, dut_valid}), 96'(3'b101));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrun_reset_outputs", all_outputs(), 96'(0));
        repeat (8) @(negedge clk);
        checkOutput("idle_ignores_inflight", all_outputs(), 96'(0));
        num_ops = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_valid = 0;
        for (int c = 0; c < 10; c++) begin
            if (dut_valid) seen_valid++;
            @(negedge clk);
        end
        checkOutput("zero_ops_done_pass", 96'({done, pass, busy, timeout, err_count}), 96'({4'b1100, 16'd0}));
        checkOutput("zero_ops_no_valid", 96'(seen_valid), 96'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
